// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings and bus width defaults for the two-master picorv32 memory bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the picorv32 native bus: one owner per transaction, an idle cycle between owners.
// Build option ARB_ROUND_ROBIN_EN: ties alternate between masters; otherwise m0 has fixed priority.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                m0_valid,
    input  logic                m0_instr,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ready,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_valid,
    input  logic                m1_instr,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                s_valid,
    output logic                s_instr,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          owner
);

    arb_state_e state_q, state_d;
    logic       last_grant_q;
    logic       tie_m1;
    logic       grant_m1;
    logic       own1;

    function automatic logic pick_m1(input logic v0, input logic v1, input logic tie);
        return v1 & (~v0 | tie);
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    assign tie_m1 = ~last_grant_q;
`else
    // Fixed priority: last_grant is still tracked but never steers a tie.
    assign tie_m1 = last_grant_q & 1'b0;
`endif

    assign grant_m1 = pick_m1(m0_valid, m1_valid, tie_m1);
    assign own1     = (state_q == ARB_OWN1);

    assign s_instr  = own1 ? m1_instr : m0_instr;
    assign s_addr   = own1 ? m1_addr  : m0_addr;
    assign s_wdata  = own1 ? m1_wdata : m0_wdata;
    assign s_wstrb  = own1 ? m1_wstrb : m0_wstrb;
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            // Only completed transactions move last_grant; aborts leave it alone.
            if (state_q == ARB_OWN0 && m0_valid && s_ready)
                last_grant_q <= 1'b0;
            else if (state_q == ARB_OWN1 && m1_valid && s_ready)
                last_grant_q <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        s_valid  = 1'b0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        owner    = 2'b00;
        unique case (state_q)
            ARB_IDLE: begin
                if (m0_valid || m1_valid)
                    state_d = grant_m1 ? ARB_OWN1 : ARB_OWN0;
            end
            ARB_OWN0: begin
                owner    = 2'b01;
                s_valid  = m0_valid;
                m0_ready = m0_valid & s_ready;
                if (!m0_valid || s_ready)
                    state_d = ARB_IDLE;
            end
            ARB_OWN1: begin
                owner    = 2'b10;
                s_valid  = m1_valid;
                m1_ready = m1_valid & s_ready;
                if (!m1_valid || s_ready)
                    state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
        // Reset silences the bus immediately, not just from the next edge.
        if (resetn) begin
            s_valid  = 1'b0;
            m0_ready = 1'b0;
            m1_ready = 1'b0;
            owner    = 2'b00;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transactions, a latency-programmable slave model,
// and a negedge monitor that pops expected completions.
module tb_mem_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  owner;

    typedef struct packed {
        logic        m;
        logic [31:0] d;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          slave_lat = 1;
    logic [31:0] slave_rd = '0;
    int          pulse_req = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata), .owner(owner)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Slave: ready after slave_lat cycles of s_valid; one-shot pulses on request even when idle.
    initial begin
        int cnt = 0;
        int pulse_ack = 0;
        s_ready = 1'b0;
        s_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (s_ready) begin
                s_ready = 1'b0;
                cnt = 0;
            end else if (pulse_req != pulse_ack) begin
                pulse_ack = pulse_req;
                s_ready = 1'b1;
                s_rdata = 32'hBAD0_BAD0;
            end else if (s_valid) begin
                cnt++;
                if (cnt >= slave_lat) begin
                    s_ready = 1'b1;
                    s_rdata = slave_rd;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: every master ready must match the next scoreboard entry; owners never switch back-to-back.
    initial begin
        logic       prev_sv = 1'b0;
        logic [1:0] prev_own = 2'b00;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin
                check("single_ready", {31'd0, m0_ready & m1_ready}, 32'd0);
                if (sb.size() == 0) begin
                    check("ready_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ready_master", {31'd0, m1_ready}, {31'd0, e.m});
                    check("ready_rdata", m1_ready ? m1_rdata : m0_rdata, e.d);
                end
            end
            if (s_valid && prev_sv)
                check("owner_gap", {30'd0, owner}, {30'd0, prev_own});
            prev_sv  = s_valid;
            prev_own = owner;
        end
    end

    task automatic drive(input bit m, input logic v, input logic ins, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
        if (m) begin
            m1_valid = v; m1_instr = ins; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
        end else begin
            m0_valid = v; m0_instr = ins; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
        end
    endtask

    // Single-master transaction; starts and ends at posedge+1.
    task automatic do_txn(input bit m, input logic ins, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [31:0] rd, input int lat);
        bit got = 1'b0;
        sb.push_back('{m: m, d: rd});
        slave_rd  = rd;
        slave_lat = lat;
        drive(m, 1'b1, ins, a, wd, ws);
        #2;
        check("arb_cycle_owner", {30'd0, owner}, 32'd0);
        check("arb_cycle_s_valid", {31'd0, s_valid}, 32'd0);
        @(posedge clk); #1;
        check("grant_owner", {30'd0, owner}, m ? 32'd2 : 32'd1);
        check("grant_s_valid", {31'd0, s_valid}, 32'd1);
        check("grant_s_instr", {31'd0, s_instr}, {31'd0, ins});
        check("grant_s_addr", s_addr, a);
        check("grant_s_wdata", s_wdata, wd);
        check("grant_s_wstrb", {28'd0, s_wstrb}, {28'd0, ws});
        for (int i = 0; i < 40 && !got; i++) begin
            #2;
            if (m ? m1_ready : m0_ready) got = 1'b1;
            @(posedge clk); #1;
        end
        check("txn_done", {31'd0, got}, 32'd1);
        drive(m, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #2;
        check("post_owner", {30'd0, owner}, 32'd0);
        check("post_s_valid", {31'd0, s_valid}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Both masters request continuously until n completions are seen.
    task automatic tie_run(input int n);
        int seen = 0;
        slave_lat = 2;
        slave_rd  = 32'h3333_0000;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'd0, 4'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h1000_0004, 32'd0, 4'd0);
        for (int i = 0; i < 200 && seen < n; i++) begin
            #2;
            if (m0_ready || m1_ready) seen++;
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("tie_count", seen, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_owner", {30'd0, owner}, 32'd0);
        check("rst_s_valid", {31'd0, s_valid}, 32'd0);
        m0_valid = 1'b1;
        @(posedge clk); #1;
        check("rst_gated_s_valid", {31'd0, s_valid}, 32'd0);
        check("rst_gated_owner", {30'd0, owner}, 32'd0);
        m0_valid = 1'b0;
        resetn   = 1'b0;
        @(posedge clk); #1;

        // 1: m0 instruction read, slow slave
        do_txn(1'b0, 1'b1, 32'h0000_0010, 32'd0, 4'd0, 32'hDEAD_BEEF, 3);
        // 2: m1 write to out_byte
        do_txn(1'b1, 1'b0, 32'h1000_0000, 32'h0000_0041, 4'b0001, 32'h0000_0000, 1);

        // 3: continuous contention, last grant was m1
        for (int i = 0; i < 4; i++)
            sb.push_back('{m: RR ? i[0] : 1'b0, d: 32'h3333_0000});
        tie_run(4);
        repeat (2) @(posedge clk);
        #1;

        // 4: m1 abort with last_grant = m0
        do_txn(1'b0, 1'b0, 32'h0000_0100, 32'h0000_1234, 4'hF, 32'h0000_5678, 2);
        slave_lat = 10;
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'd0, 4'd0);
        @(posedge clk); #1;
        check("abort_grant_owner", {30'd0, owner}, 32'd2);
        @(posedge clk); #1;
        m1_valid = 1'b0;
        #1;
        check("abort_s_valid", {31'd0, s_valid}, 32'd0);
        check("abort_m1_ready", {31'd0, m1_ready}, 32'd0);
        @(posedge clk); #1;
        check("abort_idle_owner", {30'd0, owner}, 32'd0);
        sb.push_back('{m: RR, d: 32'h3333_0000});
        tie_run(1);
        repeat (2) @(posedge clk);
        #1;

        // 5: reset in the middle of an m0 transaction, with last_grant = m0
        do_txn(1'b0, 1'b0, 32'h0000_0040, 32'd0, 4'd0, 32'h0000_4040, 1);
        slave_lat = 10;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'd0, 4'd0);
        @(posedge clk); #1;
        check("pre_rst_owner", {30'd0, owner}, 32'd1);
        @(posedge clk); #1;
        resetn = 1'b1;
        #1;
        check("mid_rst_s_valid", {31'd0, s_valid}, 32'd0);
        check("mid_rst_m0_ready", {31'd0, m0_ready}, 32'd0);
        check("mid_rst_owner", {30'd0, owner}, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        check("rst_held_owner", {30'd0, owner}, 32'd0);
        m0_valid = 1'b0;
        resetn   = 1'b0;
        sb.push_back('{m: 1'b0, d: 32'h3333_0000});
        tie_run(1);
        repeat (2) @(posedge clk);
        #1;

        // 6: stray s_ready while idle
        pulse_req++;
        #2;
        check("stray_m0_ready", {31'd0, m0_ready}, 32'd0);
        check("stray_m1_ready", {31'd0, m1_ready}, 32'd0);
        check("stray_s_valid", {31'd0, s_valid}, 32'd0);
        @(posedge clk); #1;
        check("stray_owner", {30'd0, owner}, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
